snow_fall_engine: RTL and testbench

//  Per-frame animation engine for the snow globe. It owns write port A of the 256x256x3 snow bitmap
//  (dual-port RAM; the VGA paint stage reads port B).
//  On each accepted frame_start it moves the selected snow layers down one row and spawns new flakes

---
 rtl/snow_pkg.sv | 30 +++
 rtl/snow_lfsr.sv | 25 ++
 rtl/snow_fall_engine.sv | 151 +++++++++++++++
 tb/tb_snow_fall_engine.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snow_pkg.sv
// Shared types, constants and helpers for the snow fall engine.
// Latency: n/a (declarations only).
// Backpressure: n/a. Build option SNOW_WIND_EN is consumed by snow_fall_engine.
package snow_pkg;

  localparam int LAYERS = 3;
  localparam int CORDW  = 8;

  localparam logic [15:0] DEF_TAPS = 16'b1101000000001000;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, RD, WR, SPAWN} state_t;

  // Horizontal source offset applied to the read column of the shift phase
  typedef enum logic [1:0] {DRIFT_NONE = 2'b00, DRIFT_L = 2'b01, DRIFT_R = 2'b10} drift_t;

  function automatic logic [CORDW-1:0] src_x(input logic [CORDW-1:0] x, input drift_t d);
    case (d)
      DRIFT_L: return x - 8'd1;
      DRIFT_R: return x + 8'd1;
      default: return x;
    endcase
  endfunction

  // Layer k steps when the frame counter is a multiple of 2^k
  function automatic logic [LAYERS-1:0] step_mask_for(input logic [1:0] fcnt);
    return {fcnt == 2'd0, fcnt[0] == 1'b0, 1'b1};
  endfunction

endpackage

// File: rtl/snow_lfsr.sv
// 16-bit Galois LFSR (right shift, feedback XORed in when the output bit is 1).
// Latency: one step per cycle with en high; value is the current register.
// Backpressure: none; en simply holds the state.
module snow_lfsr
  import snow_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_SEED,
  parameter logic [15:0] TAPS = DEF_TAPS
) (
  input  logic        clk_pix,
  input  logic        rst_pix_n,
  input  logic        en,
  output logic [15:0] value
);

  // Advance one Galois step per enabled cycle; reset loads the seed
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      value <= SEED;
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/snow_fall_engine.sv
// Per-frame snow animation: shifts the selected layers down one row, then spawns row 0 from an LFSR.
// Latency: 130816 cycles per pass (first RD to last SPAWN); done pulses on the last write.
// Backpressure: none; frame_start while busy is dropped and flagged in sticky overrun. Option: SNOW_WIND_EN.
module snow_fall_engine
  import snow_pkg::*;
#(
  parameter logic [7:0]  DENSITY = 8'd24,
  parameter logic [15:0] SEED    = DEF_SEED,
  parameter logic [15:0] TAPS    = DEF_TAPS
) (
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              wind_l,
  input  logic              wind_r,
  output logic [15:0]       mem_addr,
  output logic              mem_we,
  output logic [LAYERS-1:0] mem_wmask,
  output logic [LAYERS-1:0] mem_wdata,
  input  logic [LAYERS-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  state_t            state;
  logic [CORDW-1:0]  x;
  logic [CORDW-1:0]  y;
  logic [1:0]        fcnt;
  logic [LAYERS-1:0] step_mask;
  drift_t            drift;
  drift_t            drift_in;
  logic [15:0]       lfsr;
  logic              spawn_bit;
  logic              start;
  logic              unused_lfsr;

  assign start = frame_start && enable;

`ifdef SNOW_WIND_EN
  // Both wind inputs set cancel out to no drift
  assign drift_in = (wind_l && !wind_r) ? DRIFT_L :
                    (wind_r && !wind_l) ? DRIFT_R : DRIFT_NONE;
`else
  logic unused_wind;
  assign drift_in    = DRIFT_NONE;
  assign unused_wind = wind_l ^ wind_r;
`endif

  snow_lfsr #(.SEED(SEED), .TAPS(TAPS)) u_lfsr (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .en        (state == SPAWN),
    .value     (lfsr)
  );

  assign spawn_bit   = lfsr[7:0] < DENSITY;
  assign unused_lfsr = ^lfsr[15:8];

  // Write data selected by the registered state: read data lands from the RAM in the
  // WR cycle itself, so it is forwarded straight through rather than re-registered.
  always_comb begin
    mem_wdata = '0;
    case (state)
      WR:      mem_wdata = mem_rdata;
      SPAWN:   mem_wdata = {LAYERS{spawn_bit}};
      default: mem_wdata = '0;
    endcase
  end

  // Pass sequencer: outputs are loaded together with the state they belong to
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      fcnt      <= '0;
      step_mask <= '0;
      drift     <= DRIFT_NONE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wmask <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          mem_we    <= 1'b0;
          mem_wmask <= '0;
          if (start) begin
            step_mask <= step_mask_for(fcnt);
            fcnt      <= fcnt + 2'd1;
            drift     <= drift_in;
            x         <= '0;
            y         <= 8'd255;
            busy      <= 1'b1;
            mem_addr  <= {8'd254, src_x(8'd0, drift_in)};
            state     <= RD;
          end
        end
        RD: begin
          state     <= WR;
          mem_addr  <= {y, x};
          mem_we    <= 1'b1;
          mem_wmask <= step_mask;
        end
        WR: begin
          if (x == 8'd255 && y == 8'd1) begin
            state     <= SPAWN;
            x         <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b1;
            mem_wmask <= step_mask;
          end else begin
            state     <= RD;
            mem_we    <= 1'b0;
            mem_wmask <= '0;
            if (x == 8'd255) begin
              x        <= '0;
              y        <= y - 8'd1;
              mem_addr <= {y - 8'd2, src_x(8'd0, drift)};
            end else begin
              x        <= x + 8'd1;
              mem_addr <= {y - 8'd1, src_x(x + 8'd1, drift)};
            end
          end
        end
        SPAWN: begin
          if (x == 8'd255) begin
            state     <= IDLE;
            x         <= '0;
            busy      <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= '0;
            mem_addr  <= '0;
          end else begin
            x        <= x + 8'd1;
            mem_addr <= {8'd0, x + 8'd1};
            done     <= (x == 8'd254);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snow_fall_engine.sv
// Directed bench for snow_fall_engine with a behavioural 64K x 3 synchronous RAM.
// Build with or without SNOW_WIND_EN; the wind column offset adapts.
module tb_snow_fall_engine;

  localparam logic [7:0]  DENS     = 8'd128;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [15:0] TAPS     = 16'b1101000000001000;
  localparam int          PASS_CYC = 255 * 256 * 2 + 256;
`ifdef SNOW_WIND_EN
  // wind_r reads column x+1, so content moves one column to the left
  localparam int WDX = 255;
`else
  localparam int WDX = 0;
`endif

  logic        clk_pix     = 1'b0;
  logic        rst_pix_n   = 1'b0;
  logic        enable      = 1'b0;
  logic        frame_start = 1'b0;
  logic        wind_l      = 1'b0;
  logic        wind_r      = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wmask;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata   = 3'b000;
  logic        busy;
  logic        done;
  logic        overrun;

  logic        tb_clr = 1'b0;
  logic        tb_we  = 1'b0;
  logic [15:0] tb_addr = 16'h0;
  logic [2:0]  tb_dat  = 3'b000;
  logic [2:0]  ram [0:65535];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_lfsr;
  logic        exp_row1 [0:255];

  snow_fall_engine #(.DENSITY(DENS), .SEED(SEED), .TAPS(TAPS)) dut (
    .clk_pix     (clk_pix),
    .rst_pix_n   (rst_pix_n),
    .enable      (enable),
    .frame_start (frame_start),
    .wind_l      (wind_l),
    .wind_r      (wind_r),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wmask   (mem_wmask),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clk_pix = ~clk_pix;

  // RAM: read-before-write, data one cycle after the address; bench preload has priority
  always @(posedge clk_pix) begin
    mem_rdata <= ram[mem_addr];
    if (tb_clr) begin
      for (int i = 0; i < 65536; i++) ram[i] = 3'b000;
    end else if (tb_we) begin
      ram[tb_addr] = tb_dat;
    end else if (mem_we) begin
      ram[mem_addr] = (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  function automatic logic [15:0] pa(input int y, input int x);
    return {y[7:0], x[7:0]};
  endfunction

  function automatic int wx(input int x);
    return (x + WDX) % 256;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  task automatic tick();
    @(negedge clk_pix);
  endtask

  task automatic poke(input int y, input int x, input logic [2:0] v);
    tb_we = 1'b1; tb_addr = pa(y, x); tb_dat = v;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic clear_ram();
    tb_clr = 1'b1;
    tick();
    tb_clr = 1'b0;
  endtask

  // One full pass: checks pass length, write count and the return to idle
  task automatic run_pass(input int ovr_at);
    int cyc;
    int we_cnt;
    bit seen;
    enable = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL pass_busy_rise: got %b expected 1", busy);
    end
    cyc = 1; we_cnt = 0; seen = 0;
    while (cyc <= PASS_CYC + 200) begin
      if (mem_we === 1'b1) we_cnt++;
      if (done === 1'b1) begin seen = 1; break; end
      frame_start = (cyc == ovr_at);
      tick();
      cyc++;
    end
    frame_start = 1'b0;
    n_checks++;
    if (!seen || cyc != PASS_CYC) begin
      n_fail++; $display("FAIL pass_length: got %0d cycles (done seen %0b) expected %0d", cyc, seen, PASS_CYC);
    end
    n_checks++;
    if (we_cnt != 65536) begin
      n_fail++; $display("FAIL pass_writes: got %0d expected 65536", we_cnt);
    end
    tick();
    n_checks++;
    if ({busy, done, mem_we, mem_wmask} !== 6'b0) begin
      n_fail++; $display("FAIL pass_end: got busy=%b done=%b we=%b wmask=%b expected all 0", busy, done, mem_we, mem_wmask);
    end
  endtask

  task automatic test_reset();
    int bad;
    tb_clr = 1'b1;
    repeat (3) tick();
    tb_clr = 1'b0;
    n_checks++;
    if ({mem_addr, mem_we, mem_wmask, mem_wdata, busy, done, overrun} !== 26'b0) begin
      n_fail++; $display("FAIL reset_outputs: got addr=%h we=%b wmask=%b wdata=%b busy=%b done=%b ovr=%b expected all 0",
                         mem_addr, mem_we, mem_wmask, mem_wdata, busy, done, overrun);
    end
    rst_pix_n = 1'b1;
    enable = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (500) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_prepass_busy: got %b expected 1", busy);
    end
    rst_pix_n = 1'b0;
    @(posedge clk_pix); #1;
    n_checks++;
    if ({mem_we, busy, done, mem_wmask} !== 6'b0) begin
      n_fail++; $display("FAIL reset_midpass: got we=%b busy=%b done=%b wmask=%b expected all 0", mem_we, busy, done, mem_wmask);
    end
    tick();
    rst_pix_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({mem_we, busy, done, overrun, mem_wmask, mem_addr} !== 23'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reset_release_quiet: got %0d non-zero cycles expected 0", bad);
    end
  endtask

  task automatic test_enable_off();
    int we_seen;
    int busy_seen;
    enable = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    we_seen = 0; busy_seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (mem_we === 1'b1) we_seen++;
      if (busy === 1'b1) busy_seen++;
      tick();
    end
    n_checks++;
    if (we_seen != 0 || busy_seen != 0) begin
      n_fail++; $display("FAIL enable_off: got we=%0d busy=%0d cycles expected 0", we_seen, busy_seen);
    end
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL enable_off_overrun: got %b expected 0", overrun);
    end
  endtask

  task automatic test_overrun();
    clear_ram();
    poke(10, 100, 3'b001);
    poke(20, 50, 3'b111);
    poke(10, 0, 3'b001);
    model_lfsr = SEED;
    wind_r = 1'b1;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_before: got %b expected 0", overrun);
    end
    run_pass(1000);
    wind_r = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_after: got %b expected 1", overrun);
    end
  endtask

  task automatic test_fall();
    int ya [0:3];
    int xa [0:3];
    logic [2:0] ea [0:3];
    ya[0] = 11; xa[0] = wx(100); ea[0] = 3'b001;
    ya[1] = 10; xa[1] = 100;     ea[1] = 3'b000;
    ya[2] = 21; xa[2] = wx(50);  ea[2] = 3'b111;
    ya[3] = 20; xa[3] = 50;      ea[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ram[pa(ya[i], xa[i])] !== ea[i]) begin
        n_fail++; $display("FAIL fall(%0d,%0d): got %b expected %b", ya[i], xa[i], ram[pa(ya[i], xa[i])], ea[i]);
      end
    end
  endtask

  task automatic test_wind();
    n_checks++;
    if (ram[pa(11, wx(0))] !== 3'b001) begin
      n_fail++; $display("FAIL wind_land(11,%0d): got %b expected 001", wx(0), ram[pa(11, wx(0))]);
    end
    n_checks++;
    if (ram[pa(10, 0)] !== 3'b000) begin
      n_fail++; $display("FAIL wind_src(10,0): got %b expected 000", ram[pa(10, 0)]);
    end
  endtask

  task automatic test_spawn();
    logic e;
    for (int x = 0; x < 256; x++) begin
      e = (model_lfsr[7:0] < DENS);
      exp_row1[x] = e;
      model_lfsr = lfsr_next(model_lfsr);
      n_checks++;
      if (ram[pa(0, x)] !== {3{e}}) begin
        n_fail++; $display("FAIL spawn(0,%0d): got %b expected %b", x, ram[pa(0, x)], {3{e}});
      end
    end
  endtask

  task automatic test_cadence();
    logic e;
    int cx;
    int ya [0:6];
    int xa [0:6];
    logic [2:0] ea [0:6];
    // Second pass steps layer 0 only: row 0 keeps layers 1,2 from the first spawn
    run_pass(0);
    for (int x = 0; x < 256; x++) begin
      e = (model_lfsr[7:0] < DENS);
      model_lfsr = lfsr_next(model_lfsr);
      n_checks++;
      if (ram[pa(0, x)] !== {exp_row1[x], exp_row1[x], e}) begin
        n_fail++; $display("FAIL spawn2(0,%0d): got %b expected %b", x, ram[pa(0, x)], {exp_row1[x], exp_row1[x], e});
      end
    end
    run_pass(0);
    run_pass(0);
    cx = wx(50);
    ya[0] = 20; xa[0] = cx;       ea[0] = 3'b000;
    ya[1] = 21; xa[1] = cx;       ea[1] = 3'b100;
    ya[2] = 22; xa[2] = cx;       ea[2] = 3'b010;
    ya[3] = 23; xa[3] = cx;       ea[3] = 3'b000;
    ya[4] = 24; xa[4] = cx;       ea[4] = 3'b001;
    ya[5] = 14; xa[5] = wx(100);  ea[5] = 3'b001;
    ya[6] = 14; xa[6] = wx(0);    ea[6] = 3'b001;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (ram[pa(ya[i], xa[i])] !== ea[i]) begin
        n_fail++; $display("FAIL cadence(%0d,%0d): got %b expected %b", ya[i], xa[i], ram[pa(ya[i], xa[i])], ea[i]);
      end
    end
  endtask

  task automatic test_stray();
    int bits;
    bits = 0;
    for (int a = 5 * 256; a < 65536; a++) begin
      bits += int'(ram[a][0]) + int'(ram[a][1]) + int'(ram[a][2]);
    end
    n_checks++;
    if (bits != 5) begin
      n_fail++; $display("FAIL stray_bits: got %0d set bits in rows 5..255 expected 5", bits);
    end
  endtask

  initial begin
    test_reset();
    test_enable_off();
    test_overrun();
    test_fall();
    test_wind();
    test_spawn();
    test_cadence();
    test_stray();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
